mmio_return_responder: RTL and testbench

MMIO_RETURN_RESPONDER -- requirements
Module: mmio_return_responder

---
 rtl/mmio_return_responder_pkg.sv | 47 ++++
 rtl/mmio_return_fifo.sv | 50 +++++
 rtl/mmio_return_responder.sv | 142 ++++++++++++++
 tb/tb_mmio_return_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_return_responder_pkg.sv
// Shared globals for the MMIO return responder: register map, error bit
// indices and the request decode helper.
package mmio_return_responder_pkg;

  typedef logic [7:0] cu_id_t;

  // Byte addresses on the 26-bit host bus; the MMIO port carries word addresses.
  localparam logic [25:0] CU_RETURN_BADDR     = 26'h3FFFFD8;
  localparam logic [25:0] CU_RETURN_ACK_BADDR = 26'h3FFFFD0;
  localparam logic [25:0] ERROR_REG_BADDR     = 26'h3FFFFB8;
  localparam logic [25:0] ERROR_REG_ACK_BADDR = 26'h3FFFFB0;

  localparam logic [23:0] CU_RETURN_ADDR     = CU_RETURN_BADDR[25:2];
  localparam logic [23:0] CU_RETURN_ACK_ADDR = CU_RETURN_ACK_BADDR[25:2];
  localparam logic [23:0] ERROR_REG_ADDR     = ERROR_REG_BADDR[25:2];
  localparam logic [23:0] ERROR_REG_ACK_ADDR = ERROR_REG_ACK_BADDR[25:2];

  localparam int ERR_ACK_MISMATCH_BIT = 62;
  localparam int ERR_PARITY_BIT       = 63;

  typedef enum logic [1:0] {
    SEL_CU_RETURN     = 2'd0,
    SEL_CU_RETURN_ACK = 2'd1,
    SEL_ERROR_REG     = 2'd2,
    SEL_ERROR_REG_ACK = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } decode_t;

  function automatic decode_t decode_addr(input logic [23:0] addr);
    decode_t d;
    d.hit = 1'b1;
    d.sel = SEL_CU_RETURN;
    case (addr)
      CU_RETURN_ADDR:     d.sel = SEL_CU_RETURN;
      CU_RETURN_ACK_ADDR: d.sel = SEL_CU_RETURN_ACK;
      ERROR_REG_ADDR:     d.sel = SEL_ERROR_REG;
      ERROR_REG_ACK_ADDR: d.sel = SEL_ERROR_REG_ACK;
      default:            d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mmio_return_fifo.sv
// Synchronous FIFO holding pending CU return words; full/empty come from a
// registered occupancy count so they never depend on same-cycle push/pop.
module mmio_return_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_return_responder.sv
// MMIO responder for the CU return queue and sticky error register.
// Optional feature: define MMIO_PARITY_EN to check write parity and drive read parity.
module mmio_return_responder
  import mmio_return_responder_pkg::*;
#(
  parameter int RETURN_FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mmio_valid,
  input  logic        mmio_rnw,
  input  logic        mmio_dw,
  input  logic [23:0] mmio_addr,
  input  logic [63:0] mmio_wdata,
  input  logic        mmio_wpar,
  output logic        mmio_ack,
  output logic        mmio_hit,
  output logic [63:0] mmio_rdata,
  output logic        mmio_rpar,
  input  logic        ret_valid,
  output logic        ret_ready,
  input  logic [63:0] ret_data,
  input  logic [63:0] err_set,
  output logic [63:0] err_reg,
  output logic        ret_pending
);

  decode_t     dec;
  logic        req_vld_q, req_rnw_q, req_dw_q;
  reg_sel_e    req_sel_q;
  logic [63:0] req_wdata_q;
  logic        ack_q;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] err_q, err_d;
  logic [63:0] head, rd_sel, clr;
  logic        fifo_full, fifo_empty, pop, ack_err, wr_ok, par_bad;

  assign dec = decode_addr(mmio_addr);

  // Stage 1: capture only decoded requests; others vanish without an ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_vld_q   <= 1'b0;
      req_rnw_q   <= 1'b0;
      req_dw_q    <= 1'b0;
      req_sel_q   <= SEL_CU_RETURN;
      req_wdata_q <= '0;
    end else begin
      req_vld_q   <= mmio_valid & dec.hit;
      req_rnw_q   <= mmio_rnw;
      req_dw_q    <= mmio_dw;
      req_sel_q   <= dec.sel;
      req_wdata_q <= mmio_wdata;
    end
  end

`ifdef MMIO_PARITY_EN
  logic req_wpar_q;
  logic rpar_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_wpar_q <= 1'b0;
      rpar_q     <= 1'b0;
    end else begin
      req_wpar_q <= mmio_wpar;
      rpar_q     <= req_vld_q & ~(^rdata_d);
    end
  end

  // Odd parity: the data word plus its parity bit must hold an odd number of ones.
  assign par_bad   = req_vld_q & ~req_rnw_q & ~(^{req_wdata_q, req_wpar_q});
  assign mmio_rpar = rpar_q;
`else
  logic unused_wpar;
  assign unused_wpar = mmio_wpar;
  assign par_bad     = 1'b0;
  assign mmio_rpar   = 1'b0;
`endif

  // Ready comes from the registered count only, so a pop cannot free a slot early.
  assign ret_ready = ~reset & ~fifo_full;

  mmio_return_fifo #(
    .DEPTH (RETURN_FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (ret_valid & ret_ready),
    .wdata_i (ret_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Stage 2: execute the registered request and form the registered response.
  always_comb begin
    rd_sel = '0;
    case (req_sel_q)
      SEL_CU_RETURN: rd_sel = fifo_empty ? 64'h0 : head;
      SEL_ERROR_REG: rd_sel = err_q;
      default:       rd_sel = '0;
    endcase

    wr_ok   = req_vld_q & ~req_rnw_q & req_dw_q & ~par_bad;
    pop     = wr_ok & (req_sel_q == SEL_CU_RETURN_ACK) & ~fifo_empty &
              (req_wdata_q == head);
    ack_err = wr_ok & (req_sel_q == SEL_CU_RETURN_ACK) &
              (fifo_empty | (req_wdata_q != head));
    clr     = (wr_ok & (req_sel_q == SEL_ERROR_REG_ACK)) ? req_wdata_q : 64'h0;

    err_d = (err_q & ~clr) | err_set;
    err_d[ERR_ACK_MISMATCH_BIT] = err_d[ERR_ACK_MISMATCH_BIT] | ack_err;
    err_d[ERR_PARITY_BIT]       = err_d[ERR_PARITY_BIT] | par_bad;

    rdata_d = '0;
    if (req_vld_q & req_rnw_q) begin
      rdata_d = req_dw_q ? rd_sel : {rd_sel[31:0], rd_sel[31:0]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      ack_q   <= req_vld_q;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mmio_ack    = ack_q;
  assign mmio_hit    = ack_q;
  assign mmio_rdata  = rdata_q;
  assign err_reg     = err_q;
  assign ret_pending = ~fifo_empty;

endmodule

// File: tb/tb_mmio_return_responder.sv
// Directed self-checking bench for mmio_return_responder (either MMIO_PARITY_EN build).
module tb_mmio_return_responder;

  localparam logic [23:0] A_RET     = 24'hFFFFF6;
  localparam logic [23:0] A_RET_ACK = 24'hFFFFF4;
  localparam logic [23:0] A_ERR     = 24'hFFFFEE;
  localparam logic [23:0] A_ERR_ACK = 24'hFFFFEC;
  localparam logic [63:0] B62       = 64'h4000_0000_0000_0000;
  localparam logic [63:0] B63       = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mmio_valid = 1'b0, mmio_rnw = 1'b0, mmio_dw = 1'b0;
  logic [23:0] mmio_addr = '0;
  logic [63:0] mmio_wdata = '0;
  logic        mmio_wpar = 1'b0;
  logic        mmio_ack, mmio_hit, mmio_rpar;
  logic [63:0] mmio_rdata;
  logic        ret_valid = 1'b0;
  logic        ret_ready;
  logic [63:0] ret_data = '0;
  logic [63:0] err_set = '0;
  logic [63:0] err_reg;
  logic        ret_pending;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_err = '0;

  mmio_return_responder #(.RETURN_FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .mmio_valid  (mmio_valid),
    .mmio_rnw    (mmio_rnw),
    .mmio_dw     (mmio_dw),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_wpar   (mmio_wpar),
    .mmio_ack    (mmio_ack),
    .mmio_hit    (mmio_hit),
    .mmio_rdata  (mmio_rdata),
    .mmio_rpar   (mmio_rpar),
    .ret_valid   (ret_valid),
    .ret_ready   (ret_ready),
    .ret_data    (ret_data),
    .err_set     (err_set),
    .err_reg     (err_reg),
    .ret_pending (ret_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_parity(input logic [63:0] d);
`ifdef MMIO_PARITY_EN
    return ~(^d);
`else
    return 1'b0 & d[0];
`endif
  endfunction

  // Issue one access and check the ack lands exactly two cycles later.
  task automatic mmio_xfer(input string tag, input logic rnw, input logic dw,
                           input logic [23:0] addr, input logic [63:0] wdata,
                           input logic bad_par, input logic [63:0] exp_rd);
    logic [63:0] exp_bus;
    exp_bus    = rnw ? exp_rd : 64'h0;
    mmio_valid = 1'b1;
    mmio_rnw   = rnw;
    mmio_dw    = dw;
    mmio_addr  = addr;
    mmio_wdata = wdata;
    mmio_wpar  = ~(^wdata) ^ bad_par;
    tick;
    mmio_valid = 1'b0;
    check({tag, ":ack_p1"}, 64'(mmio_ack), 64'h0);
    tick;
    check({tag, ":ack_p2"}, 64'(mmio_ack), 64'h1);
    check({tag, ":hit_p2"}, 64'(mmio_hit), 64'h1);
    check({tag, ":rdata"}, mmio_rdata, exp_bus);
    check({tag, ":rpar"}, 64'(mmio_rpar), 64'(exp_parity(exp_bus)));
    tick;
    check({tag, ":ack_p3"}, 64'(mmio_ack), 64'h0);
    check({tag, ":rdata_idle"}, mmio_rdata, 64'h0);
  endtask

  task automatic push(input logic [63:0] v);
    check("push_ready", 64'(ret_ready), 64'h1);
    ret_valid = 1'b1;
    ret_data  = v;
    tick;
    ret_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic pop_head(input string tag);
    mmio_xfer({tag, "_rd"}, 1'b1, 1'b1, A_RET, 64'h0, 1'b0, exp_q[0]);
    mmio_xfer({tag, "_ack"}, 1'b0, 1'b1, A_RET_ACK, exp_q[0], 1'b0, 64'h0);
    void'(exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    tick; tick;
    check("rst_ack", 64'(mmio_ack), 64'h0);
    check("rst_hit", 64'(mmio_hit), 64'h0);
    check("rst_rdata", mmio_rdata, 64'h0);
    check("rst_rpar", 64'(mmio_rpar), 64'h0);
    check("rst_pending", 64'(ret_pending), 64'h0);
    check("rst_err", err_reg, 64'h0);
    check("rst_ready", 64'(ret_ready), 64'h0);
    reset = 1'b0;
    tick;
    check("post_rst_ready", 64'(ret_ready), 64'h1);

    // Push then read without popping
    push(64'hA5);
    check("pend_after_push", 64'(ret_pending), 64'h1);
    mmio_xfer("rd_a5", 1'b1, 1'b1, A_RET, 64'h0, 1'b0, exp_q[0]);
    check("pend_after_rd", 64'(ret_pending), 64'h1);

    // Mismatching ack raises bit 62 and leaves the head in place
    mmio_xfer("ack_5a", 1'b0, 1'b1, A_RET_ACK, 64'h5A, 1'b0, 64'h0);
    exp_err = exp_err | B62;
    check("mis_pend", 64'(ret_pending), 64'h1);
    check("mis_err", err_reg, exp_err);
    mmio_xfer("rd_err", 1'b1, 1'b1, A_ERR, 64'h0, 1'b0, exp_err);
    mmio_xfer("ack_a5", 1'b0, 1'b1, A_RET_ACK, 64'hA5, 1'b0, 64'h0);
    void'(exp_q.pop_front());
    check("pop_pend", 64'(ret_pending), 64'h0);
    mmio_xfer("clr62", 1'b0, 1'b1, A_ERR_ACK, B62, 1'b0, 64'h0);
    exp_err = 64'h0;
    check("clr62_err", err_reg, exp_err);

    // Empty queue: read 0, ack is an error
    mmio_xfer("rd_empty", 1'b1, 1'b1, A_RET, 64'h0, 1'b0, 64'h0);
    mmio_xfer("ack_empty", 1'b0, 1'b1, A_RET_ACK, 64'h0, 1'b0, 64'h0);
    check("ack_empty_err", err_reg, B62);
    mmio_xfer("clr62b", 1'b0, 1'b1, A_ERR_ACK, B62, 1'b0, 64'h0);
    check("clr62b_err", err_reg, 64'h0);

    // 32-bit accesses, ACK-address reads and read-only writes
    push(64'h1111_2222_3333_4444);
    mmio_xfer("rd_sw", 1'b1, 1'b0, A_RET, 64'h0, 1'b0, 64'h3333_4444_3333_4444);
    mmio_xfer("ack_sw", 1'b0, 1'b0, A_RET_ACK, 64'h1111_2222_3333_4444, 1'b0, 64'h0);
    check("ack_sw_pend", 64'(ret_pending), 64'h1);
    check("ack_sw_err", err_reg, 64'h0);
    mmio_xfer("rd_ackaddr", 1'b1, 1'b1, A_RET_ACK, 64'h0, 1'b0, 64'h0);
    mmio_xfer("rd_erracka", 1'b1, 1'b1, A_ERR_ACK, 64'h0, 1'b0, 64'h0);
    mmio_xfer("wr_ro", 1'b0, 1'b1, A_RET, 64'hDEAD, 1'b0, 64'h0);
    mmio_xfer("wr_ro_err", 1'b0, 1'b1, A_ERR, 64'hFFFF, 1'b0, 64'h0);
    check("wr_ro_errreg", err_reg, 64'h0);
    pop_head("sw");
    check("sw_pend", 64'(ret_pending), 64'h0);

    // Fill to depth, then ack the head in the same cycle as the 5th ret_valid
    for (int i = 1; i <= 4; i++) push(64'(i));
    check("full_ready", 64'(ret_ready), 64'h0);
    ret_valid  = 1'b1;
    ret_data   = 64'h5;
    mmio_valid = 1'b1;
    mmio_rnw   = 1'b0;
    mmio_dw    = 1'b1;
    mmio_addr  = A_RET_ACK;
    mmio_wdata = exp_q[0];
    mmio_wpar  = ~(^exp_q[0]);
    tick;
    mmio_valid = 1'b0;
    check("full_ready_c1", 64'(ret_ready), 64'h0);
    tick;
    check("full_ack_c2", 64'(mmio_ack), 64'h1);
    check("full_ready_c2", 64'(ret_ready), 64'h1);
    tick;
    ret_valid = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(64'h5);
    check("refull_ready", 64'(ret_ready), 64'h0);
    for (int i = 0; i < 4; i++) pop_head("order");
    check("order_pend", 64'(ret_pending), 64'h0);
    check("order_err", err_reg, 64'h0);

    // Set wins over same-cycle W1C clear
    err_set = 64'h8;
    tick;
    check("errset", err_reg, 64'h8);
    mmio_xfer("w1c_hold", 1'b0, 1'b1, A_ERR_ACK, 64'h8, 1'b0, 64'h0);
    check("w1c_hold_err", err_reg, 64'h8);
    err_set = 64'h0;
    mmio_xfer("w1c_clr", 1'b0, 1'b1, A_ERR_ACK, 64'h8, 1'b0, 64'h0);
    check("w1c_clr_err", err_reg, 64'h0);

    // Undecoded address
    mmio_valid = 1'b1;
    mmio_rnw   = 1'b1;
    mmio_addr  = 24'h000010;
    tick;
    mmio_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nodec_ack", 64'(mmio_ack), 64'h0);
      check("nodec_hit", 64'(mmio_hit), 64'h0);
      tick;
    end

    // Back-to-back reads
    push(64'hCAFE_0000_BEEF_0001);
    err_set = 64'h10;
    tick;
    err_set = 64'h0;
    mmio_valid = 1'b1;
    mmio_rnw   = 1'b1;
    mmio_dw    = 1'b1;
    mmio_addr  = A_RET;
    tick;
    mmio_addr  = A_ERR;
    tick;
    mmio_valid = 1'b0;
    check("b2b_ack0", 64'(mmio_ack), 64'h1);
    check("b2b_rd0", mmio_rdata, exp_q[0]);
    tick;
    check("b2b_ack1", 64'(mmio_ack), 64'h1);
    check("b2b_rd1", mmio_rdata, 64'h10);
    tick;
    check("b2b_ack2", 64'(mmio_ack), 64'h0);
    pop_head("b2b");
    mmio_xfer("b2b_clr", 1'b0, 1'b1, A_ERR_ACK, 64'h10, 1'b0, 64'h0);
    check("b2b_err", err_reg, 64'h0);

    // Bad write parity
    push(64'h77);
`ifdef MMIO_PARITY_EN
    mmio_xfer("par_ack", 1'b0, 1'b1, A_RET_ACK, 64'h77, 1'b1, 64'h0);
    check("par_pend", 64'(ret_pending), 64'h1);
    check("par_err", err_reg, B63);
    mmio_xfer("par_clr", 1'b0, 1'b1, A_ERR_ACK, B63, 1'b0, 64'h0);
    check("par_clr_err", err_reg, 64'h0);
`else
    mmio_xfer("par_ack", 1'b0, 1'b1, A_RET_ACK, 64'h77, 1'b1, 64'h0);
    void'(exp_q.pop_front());
    check("par_pend", 64'(ret_pending), 64'h0);
    check("par_err", err_reg, 64'h0);
    push(64'h77);
`endif

    // Reset while a request is in flight
    err_set = B63;
    tick;
    err_set = 64'h0;
    mmio_valid = 1'b1;
    mmio_rnw   = 1'b1;
    mmio_addr  = A_RET;
    tick;
    mmio_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick;
    check("midrst_ack", 64'(mmio_ack), 64'h0);
    check("midrst_hit", 64'(mmio_hit), 64'h0);
    check("midrst_rdata", mmio_rdata, 64'h0);
    check("midrst_err", err_reg, 64'h0);
    check("midrst_pend", 64'(ret_pending), 64'h0);
    check("midrst_ready", 64'(ret_ready), 64'h0);
    reset = 1'b0;
    tick;
    check("postrst_ack", 64'(mmio_ack), 64'h0);
    tick;
    check("postrst_ack2", 64'(mmio_ack), 64'h0);
    check("postrst_ready", 64'(ret_ready), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
